// File: rtl/noise_req_scheduler.sv
// Round-robin arbiter sharing one 24-bit LFSR noise core: seeds it, steps it per grant, reseeds on lockup.
// Latency: req seen in IDLE at t -> step at t+1 -> ack/sample at t+3; requesters hold req until ack (level backpressure).
module noise_req_scheduler #(
    parameter int          NUM_REQ = 4,
    parameter logic [23:0] SEED    = 24'h000001,
    parameter int          IDX_W   = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [4*NUM_REQ-1:0]   i_shift_cfg,
    output logic [NUM_REQ-1:0]     o_ack,
    output logic [IDX_W-1:0]       o_gnt_idx,
    output logic [15:0]            o_sample,
    output logic                   o_lfsr_load,
    output logic [23:0]            o_lfsr_seed,
    output logic                   o_lfsr_step,
    input  logic [23:0]            i_lfsr_state
);

    typedef enum logic [2:0] {
        S_SEED,
        S_SETTLE,
        S_IDLE,
        S_STEP,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_win;
    logic [IDX_W-1:0]     r_gnt_idx;
    logic [NUM_REQ-1:0]   r_mask;
    logic [15:0]          r_sample;
    logic [NUM_REQ-1:0]   w_elig;
    logic [IDX_W-1:0]     w_idx;
    logic [IDX_W-1:0]     w_win;
    logic                 w_found;
    logic                 w_lockup;
    logic                 w_grant;
    logic [3:0]           w_shift_raw;
    logic [3:0]           w_shift;
    logic [15:0]          w_sample;

    // Round-robin scan starting just after the last winner.
    always_comb begin
        w_elig  = i_req & ~r_mask;
        w_found = 1'b0;
        w_win   = r_rr_ptr;
        w_idx   = r_rr_ptr;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = IDX_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_lockup    = (i_lfsr_state == 24'd0);
    assign w_grant     = (r_state == S_IDLE) && !w_lockup && w_found;
    assign w_shift_raw = i_shift_cfg[{r_win, 2'b00} +: 4];
    assign w_shift     = (w_shift_raw > 4'd8) ? 4'd8 : w_shift_raw;
    assign w_sample    = 16'(i_lfsr_state >> w_shift);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= S_SEED;
            r_rr_ptr  <= IDX_W'(NUM_REQ - 1);
            r_win     <= '0;
            r_gnt_idx <= '0;
            r_mask    <= '0;
            r_sample  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                r_mask <= '0;
            end
            if (w_grant) begin
                r_win    <= w_win;
                r_rr_ptr <= w_win;
            end
            if (r_state == S_DELIVER) begin
                r_mask    <= NUM_REQ'(1) << r_win;
                r_gnt_idx <= r_win;
                r_sample  <= w_sample;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        o_ack       = '0;
        o_gnt_idx   = r_gnt_idx;
        o_sample    = r_sample;
        o_lfsr_load = 1'b0;
        o_lfsr_seed = '0;
        o_lfsr_step = 1'b0;
        case (r_state)
            S_SEED: begin
                o_lfsr_load = 1'b1;
                o_lfsr_seed = SEED;
                w_next      = S_SETTLE;
            end
            S_SETTLE: w_next = S_IDLE;
            S_IDLE: begin
                // A zero state never leaves zero, so recovery beats arbitration.
                if (w_lockup) begin
                    o_lfsr_load = 1'b1;
                    o_lfsr_seed = ~SEED;
                    w_next      = S_SETTLE;
                end else if (w_found) begin
                    w_next = S_STEP;
                end
            end
            S_STEP: begin
                o_lfsr_step = 1'b1;
                w_next      = S_WAIT;
            end
            S_WAIT: w_next = S_DELIVER;
            S_DELIVER: begin
                o_ack     = NUM_REQ'(1) << r_win;
                o_gnt_idx = r_win;
                o_sample  = w_sample;
                w_next    = S_IDLE;
            end
            default: w_next = S_SEED;
        endcase
        // Outputs read as zero for the whole time reset is held.
        if (!i_reset) begin
            o_ack       = '0;
            o_gnt_idx   = '0;
            o_sample    = '0;
            o_lfsr_load = 1'b0;
            o_lfsr_seed = '0;
            o_lfsr_step = 1'b0;
        end
    end

endmodule

// File: tb/tb_noise_req_scheduler.sv
// Bench for noise_req_scheduler: table of single grants plus hand sequences, with an LFSR core model.
module tb_noise_req_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] shift_cfg;
    logic [3:0]  ack;
    logic [1:0]  gnt;
    logic [15:0] sample;
    logic        load;
    logic [23:0] seed;
    logic        step;
    logic [23:0] lfsr;
    logic        force_en;
    logic [23:0] force_val;

    int total;
    int bad;
    int cyc;
    int load_cnt;
    int step_cnt;
    bit auto_drop;

    typedef struct {
        logic [1:0]  gnt;
        logic [15:0] smp;
    } exp_t;

    typedef struct {
        logic [1:0]  id;
        logic [3:0]  sh;
        logic [15:0] smp;
    } vec_t;

    exp_t sb[$];
    int   ack_cyc[$];
    vec_t vt[6];

    noise_req_scheduler #(
        .NUM_REQ(4),
        .SEED   (24'h000001),
        .IDX_W  (2)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_req       (req),
        .i_shift_cfg (shift_cfg),
        .o_ack       (ack),
        .o_gnt_idx   (gnt),
        .o_sample    (sample),
        .o_lfsr_load (load),
        .o_lfsr_seed (seed),
        .o_lfsr_step (step),
        .i_lfsr_state(lfsr)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] lfsr_nx(logic [23:0] s);
        return {s[22:0], s[23] ^ s[22] ^ s[20] ^ s[19]};
    endfunction

    // Shared core: registered, load wins over step; force_en lets the bench plant a state.
    always @(posedge clk) begin
        if (force_en)  lfsr <= force_val;
        else if (load) lfsr <= seed;
        else if (step) lfsr <= lfsr_nx(lfsr);
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    task automatic exp_push(logic [1:0] g, logic [15:0] s);
        exp_t e;
        e.gnt = g;
        e.smp = s;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        check("load_step_exclusive", 32'(load & step), 32'd0);
        if (load) load_cnt++;
        if (step) step_cnt++;
        if (|ack) begin
            ack_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_onehot", 32'(ack), 32'(4'b0001 << e.gnt));
                check("gnt_idx", 32'(gnt), 32'(e.gnt));
                check("sample", 32'(sample), 32'(e.smp));
            end
            if (auto_drop) req[gnt] = 1'b0;
        end
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        int s0;
        int l0;
        int c0;

        vt[0] = '{id: 2'd0, sh: 4'd0, smp: 16'h0002};
        vt[1] = '{id: 2'd1, sh: 4'd0, smp: 16'h0004};
        vt[2] = '{id: 2'd2, sh: 4'd1, smp: 16'h0004};
        vt[3] = '{id: 2'd1, sh: 4'd4, smp: 16'h0001};
        vt[4] = '{id: 2'd2, sh: 4'd0, smp: 16'h0020};
        vt[5] = '{id: 2'd3, sh: 4'd5, smp: 16'h0002};

        clk = 0; rst_n = 0; req = '0; shift_cfg = '0;
        force_en = 0; force_val = '0; lfsr = '0;
        total = 0; bad = 0; cyc = 0; load_cnt = 0; step_cnt = 0; auto_drop = 1;

        // Reset for 3 cycles, then a single seed load and the first IDLE.
        repeat (3) begin
            tick();
            check("rst_ack", 32'(ack), 32'd0);
            check("rst_load_step", 32'({load, step}), 32'd0);
        end
        check("rst_outputs", 32'({gnt, sample}), 32'd0);
        check("rst_seed", 32'(seed), 32'd0);
        @(posedge clk);
        #1 rst_n = 1;
        l0 = load_cnt;
        tick();
        check("seed_load", 32'(load), 32'd1);
        check("seed_value", 32'(seed), 32'h000001);
        check("seed_no_ack", 32'(ack), 32'd0);
        tick();
        check("settle_no_load", 32'({load, ack}), 32'd0);
        tick();
        check("one_load_pulse", 32'(load_cnt - l0), 32'd1);

        // Table: one requester at a time, other nibbles hold a decoy shift.
        for (int r = 0; r < 6; r++) begin
            tick();
            shift_cfg = 16'h7777;
            shift_cfg[{vt[r].id, 2'b00} +: 4] = vt[r].sh;
            req = '0;
            req[vt[r].id] = 1'b1;
            exp_push(vt[r].id, vt[r].smp);
            s0 = step_cnt;
            tick();
            check("lat_step", 32'(step), 32'd1);
            tick();
            check("lat_wait", 32'({step, |ack}), 32'd0);
            tick();
            check("lat_ack", 32'(ack_cyc.size() > 0 && ack_cyc[ack_cyc.size()-1] == cyc), 32'd1);
            check("steps_per_ack", 32'(step_cnt - s0), 32'd1);
        end

        // All four held: strict rotation 0,1,2,3,0 every 4 cycles.
        tick();
        shift_cfg = '0;
        auto_drop = 0;
        req = 4'b1111;
        ack_cyc.delete();
        s0 = step_cnt;
        exp_push(2'd0, 16'h0080);
        exp_push(2'd1, 16'h0100);
        exp_push(2'd2, 16'h0200);
        exp_push(2'd3, 16'h0400);
        exp_push(2'd0, 16'h0800);
        drain(40);
        req = '0;
        auto_drop = 1;
        check("rr_ack_count", 32'(ack_cyc.size()), 32'd5);
        if (ack_cyc.size() == 5)
            for (int i = 1; i < 5; i++)
                check("rr_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
        check("rr_steps", 32'(step_cnt - s0), 32'd5);

        // Holding req across the ack: masked for one IDLE, then served again.
        tick();
        auto_drop = 0;
        req = 4'b0010;
        ack_cyc.delete();
        exp_push(2'd1, 16'h1000);
        drain(10);
        exp_push(2'd1, 16'h2000);
        tick();
        tick();
        check("mask_no_regrant", 32'(step), 32'd0);
        auto_drop = 1;
        drain(10);
        check("mask_reserve_gap", 32'(ack_cyc.size() == 2 ? ack_cyc[1] - ack_cyc[0] : 0), 32'd5);

        // Lockup at zero: reseed with ~SEED ahead of a pending request.
        tick();
        force_en = 1;
        force_val = 24'h000000;
        tick();
        force_en = 0;
        c0 = cyc;
        check("lock_load", 32'(load), 32'd1);
        check("lock_seed", 32'(seed), 32'hFFFFFE);
        check("lock_no_ack_step", 32'({step, ack}), 32'd0);
        req = 4'b0001;
        ack_cyc.delete();
        exp_push(2'd0, 16'hFFFC);
        drain(12);
        check("lock_served_after_settle", 32'(ack_cyc.size() > 0 ? ack_cyc[0] - c0 : 0), 32'd5);

        // Clamp 15 -> 8 on planted state; req dropped mid-grant still acks.
        tick();
        req = 4'b0100;
        shift_cfg = 16'h0F00;
        exp_push(2'd2, 16'hABCD);
        tick();
        req = '0;
        force_en = 1;
        force_val = 24'hABCDEF;
        tick();
        force_en = 0;
        drain(5);
        // Shift sampled at DELIVER: changed during WAIT.
        tick();
        req = 4'b1000;
        shift_cfg = 16'h0000;
        exp_push(2'd3, 16'hBCDE);
        tick();
        force_en = 1;
        force_val = 24'hABCDEF;
        tick();
        force_en = 0;
        shift_cfg = 16'h4000;
        drain(5);

        // Reset during WAIT aborts; afterwards reseed and arbitrate from requester 0.
        tick();
        req = 4'b0100;
        shift_cfg = '0;
        tick();
        tick();
        rst_n = 0;
        req = 4'b1100;
        repeat (2) begin
            tick();
            check("abort_quiet", 32'({ack, load, step}), 32'd0);
            check("abort_outputs", 32'({gnt, sample}), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1;
        tick();
        check("reseed_load", 32'(load), 32'd1);
        check("reseed_value", 32'(seed), 32'h000001);
        exp_push(2'd2, 16'h0002);
        exp_push(2'd3, 16'h0004);
        drain(20);
        tick();
        check("hold_no_ack", 32'(ack), 32'd0);
        check("hold_sample", 32'(sample), 32'h0004);
        check("hold_gnt", 32'(gnt), 32'd3);

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
